// File: rtl/vec_seq_pkg.sv
// Shared constants and types for the vector stream sequencer.
package vec_seq_pkg;

  localparam int unsigned BYTES_PER_BEAT = 8;
  localparam int unsigned BEAT_SHIFT     = 3;

  // FSM encoding kept as plain constants for compatibility with older tooling
  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t ISSUE  = 2'd1;
  localparam state_t FINISH = 2'd2;

  typedef logic [BYTES_PER_BEAT-1:0] lane_mask_t;

endpackage

// File: rtl/lane_mask_gen.sv
// Maps the bytes still outstanding in a command to the lane mask and last flag
// of the beat that covers them.
module lane_mask_gen
  import vec_seq_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic [LEN_W-1:0]          remaining,
  output logic [BYTES_PER_BEAT-1:0] mask,
  output logic                      last
);

  // Full beat when 8+ bytes remain, otherwise the low 'remaining' lanes
  always_comb begin
    last = (remaining <= LEN_W'(BYTES_PER_BEAT));
    if (remaining >= LEN_W'(BYTES_PER_BEAT)) begin
      mask = '1;
    end else begin
      mask = lane_mask_t'((16'd1 << remaining[BEAT_SHIFT-1:0]) - 16'd1);
    end
  end

endmodule

// File: rtl/vector_stream_sequencer.sv
// Walks a byte buffer in 64-bit beats, presenting address, lane mask, last flag
// and the scalar-broadcast select to the vector datapath. All outputs registered.
module vector_stream_sequencer
  import vec_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned LANES  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_scalar,
  input  logic              abort,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [ADDR_W-1:0] beat_addr,
  output logic [LANES-1:0]  beat_lane_mask,
  output logic              beat_se_sel,
  output logic              beat_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              se_q, se_d;
  logic              valid_q, valid_d;
  lane_mask_t        mask_q, mask_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;

  lane_mask_t        gen_mask;
  logic              gen_last;
  logic              accept;
  logic              hs;
  logic              issuing;

  // Mask/last are computed from the next remaining count so they can be registered
  lane_mask_gen #(
    .LEN_W(LEN_W)
  ) u_lane_mask_gen (
    .remaining(rem_d),
    .mask     (gen_mask),
    .last     (gen_last)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    se_d    = se_q;
    err_d   = 1'b0;
    // rdy_q is only ever high in IDLE, so it doubles as the IDLE qualifier
    accept  = cmd_valid && rdy_q;
    hs      = valid_q && beat_ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd_base[BEAT_SHIFT-1:0] != '0) begin
            err_d = 1'b1;
          end else if (cmd_len == '0) begin
            state_d = FINISH;
          end else begin
            addr_d  = cmd_base;
            rem_d   = cmd_len;
            se_d    = cmd_scalar;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (hs) begin
          // Address wraps silently; remaining may underflow only on exit
          addr_d = addr_q + ADDR_W'(BYTES_PER_BEAT);
          rem_d  = rem_q - LEN_W'(BYTES_PER_BEAT);
          if (last_q) state_d = FINISH;
        end
        if (abort) state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    issuing = (state_d == ISSUE);
    if (!issuing) se_d = 1'b0;
    valid_d = issuing;
    mask_d  = issuing ? gen_mask : '0;
    last_d  = issuing && gen_last;
    done_d  = (state_d == FINISH);
    rdy_d   = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers; reset discards any command in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      se_q    <= 1'b0;
      valid_q <= 1'b0;
      mask_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      se_q    <= se_d;
      valid_q <= valid_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign cmd_ready      = rdy_q;
  assign beat_valid     = valid_q;
  assign beat_addr      = addr_q;
  assign beat_lane_mask = LANES'(mask_q);
  assign beat_se_sel    = se_q;
  assign beat_last      = last_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_vector_stream_sequencer.sv
// Directed scoreboard bench for vector_stream_sequencer.
module tb_vector_stream_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_scalar, abort;
  logic [31:0] cmd_base;
  logic [15:0] cmd_len;
  logic        beat_valid, beat_ready, beat_se_sel, beat_last;
  logic [31:0] beat_addr;
  logic [7:0]  beat_lane_mask;
  logic        busy, done, err;

  logic [15:0] lm_rem;
  logic [7:0]  lm_mask;
  logic        lm_last;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  m;
    logic        l;
    logic        s;
  } beat_t;

  beat_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0, bv_cnt = 0, stall_cnt = 0;
  int last_hs_cyc = 0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr;
  logic [7:0]  prev_mask;
  logic        prev_last, prev_se;

  vector_stream_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_base      (cmd_base),
    .cmd_len       (cmd_len),
    .cmd_scalar    (cmd_scalar),
    .abort         (abort),
    .beat_valid    (beat_valid),
    .beat_ready    (beat_ready),
    .beat_addr     (beat_addr),
    .beat_lane_mask(beat_lane_mask),
    .beat_se_sel   (beat_se_sel),
    .beat_last     (beat_last),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  lane_mask_gen #(
    .LEN_W(16)
  ) u_lmg (
    .remaining(lm_rem),
    .mask     (lm_mask),
    .last     (lm_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: pop scoreboard on each handshake, check stability while stalled
  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      prev_stall = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (beat_valid) bv_cnt++;
      if (prev_stall) begin
        check("hold_valid", beat_valid, 1);
        check("hold_addr", beat_addr, prev_addr);
        check("hold_mask", beat_lane_mask, prev_mask);
        check("hold_last", beat_last, prev_last);
        check("hold_se", beat_se_sel, prev_se);
      end
      if (beat_valid && beat_ready) begin
        check("beat_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          beat_t e;
          e = sb.pop_front();
          check("beat_addr", beat_addr, e.a);
          check("beat_mask", beat_lane_mask, e.m);
          check("beat_last", beat_last, e.l);
          check("beat_se_sel", beat_se_sel, e.s);
        end
        hs_cnt++;
        last_hs_cyc = cyc;
      end
      if (beat_valid && !beat_ready) stall_cnt++;
      prev_stall = beat_valid && !beat_ready;
      prev_addr  = beat_addr;
      prev_mask  = beat_lane_mask;
      prev_last  = beat_last;
      prev_se    = beat_se_sel;
    end
  end

  // Push expected beats (up to max_beats, negative = all), then offer the command
  task automatic run_cmd(input logic [31:0] base, input logic [15:0] len, input logic sc,
                         input int max_beats);
    logic [31:0] a;
    int          rem;
    int          n;
    int          t;
    a = base;
    rem = int'(len);
    n = 0;
    if (base[2:0] == 3'b000) begin
      while (rem > 0 && (max_beats < 0 || n < max_beats)) begin
        beat_t e;
        e.a = a;
        e.m = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
        e.l = (rem <= 8);
        e.s = sc;
        sb.push_back(e);
        a = a + 32'd8;
        rem = rem - 8;
        n++;
      end
    end
    t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("cmd_ready_timeout", cmd_ready, 1);
    cmd_base = base;
    cmd_len = len;
    cmd_scalar = sc;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_base = 32'hDEAD_BEEF;
    cmd_len = 16'hFFFF;
  endtask

  task automatic wait_done(input logic chk_timing);
    int t;
    t = 0;
    while (t < 200) begin
      @(negedge clk);
      if (done === 1'b1) break;
      t++;
    end
    check("done_timeout", done, 1);
    if (chk_timing) check("done_after_last_beat", cyc, last_hs_cyc + 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("ready_after_done", cmd_ready, 1);
  endtask

  initial begin
    int h0, d0, e0, b0, v0, s0;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_base = '0;
    cmd_len = '0;
    cmd_scalar = 1'b0;
    abort = 1'b0;
    beat_ready = 1'b1;
    lm_rem = '0;

    // Standalone lane mask generator sweep
    for (int r = 0; r <= 20; r++) begin
      logic [7:0] em;
      lm_rem = 16'(r);
      #1;
      em = (r >= 8) ? 8'hFF : 8'((1 << r) - 1);
      check("lmg_mask", lm_mask, em);
      check("lmg_last", lm_last, (r <= 8));
    end

    // Reset state and release
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_beat_valid", beat_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_addr", beat_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_before_edge", cmd_ready, 0);
    @(posedge clk);
    #1;
    check("ready_after_release", cmd_ready, 1);

    // Basic run
    h0 = hs_cnt; d0 = done_cnt;
    run_cmd(32'h100, 16'd24, 1'b0, -1);
    wait_done(1'b1);
    check("basic_beats", hs_cnt - h0, 3);
    check("basic_done", done_cnt - d0, 1);

    // Partial beat, scalar mode
    h0 = hs_cnt;
    run_cmd(32'h200, 16'd13, 1'b1, -1);
    wait_done(1'b1);
    check("scalar_beats", hs_cnt - h0, 2);

    // Backpressure on beat 1
    h0 = hs_cnt; s0 = stall_cnt;
    beat_ready = 1'b0;
    run_cmd(32'h300, 16'd16, 1'b0, -1);
    repeat (3) @(posedge clk);
    #1;
    beat_ready = 1'b1;
    wait_done(1'b1);
    check("bp_beats", hs_cnt - h0, 2);
    check("bp_stalls", stall_cnt - s0, 3);

    // Zero-length command
    d0 = done_cnt; b0 = busy_cnt; v0 = bv_cnt;
    run_cmd(32'h400, 16'd0, 1'b0, -1);
    wait_done(1'b0);
    check("len0_done", done_cnt - d0, 1);
    check("len0_busy", busy_cnt - b0, 1);
    check("len0_valid", bv_cnt - v0, 0);

    // Misaligned command
    d0 = done_cnt; e0 = err_cnt; v0 = bv_cnt;
    run_cmd(32'h103, 16'd16, 1'b0, -1);
    check("err_pulse_now", err, 1);
    repeat (5) @(negedge clk);
    check("err_count", err_cnt - e0, 1);
    check("err_no_beats", bv_cnt - v0, 0);
    check("err_no_done", done_cnt - d0, 0);
    check("err_ready", cmd_ready, 1);

    // Abort coincident with beat-2 handshake
    h0 = hs_cnt; d0 = done_cnt;
    run_cmd(32'h500, 16'd32, 1'b0, 2);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    wait_done(1'b1);
    check("abort_beats", hs_cnt - h0, 2);
    check("abort_done", done_cnt - d0, 1);

    // Reset during beat 3
    d0 = done_cnt;
    run_cmd(32'h600, 16'd32, 1'b0, -1);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", beat_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", cmd_ready, 0);
    check("mid_rst_addr", beat_addr, 0);
    check("mid_rst_mask", beat_lane_mask, 0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("ready_low_after_release", cmd_ready, 0);
    @(posedge clk);
    #1;
    check("ready_first_edge", cmd_ready, 1);
    repeat (4) @(negedge clk);
    check("mid_rst_no_done", done_cnt - d0, 0);

    // Address wrap
    h0 = hs_cnt; e0 = err_cnt;
    run_cmd(32'hFFFF_FFF8, 16'd16, 1'b0, -1);
    wait_done(1'b1);
    check("wrap_beats", hs_cnt - h0, 2);
    check("wrap_no_err", err_cnt - e0, 0);

    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_stream_sequencer.md
Name: vector_stream_sequencer

Overview:
- Walks a byte buffer (image block) in 64-bit beats for the vector execute stage.
- Per beat, drives the word address, lane mask and last flag to the vector datapath.
- Also drives the scalar-broadcast select that makes the operand-2 extender replicate byte [7:0] across all 8 lanes.
- Takes one command at a time on a valid/ready port and issues beats on a valid/ready port toward the datapath.

Parameters:
ADDR_W, 32, byte-address width
LEN_W, 16, byte-count width
LANES, 8, byte lanes per 64-bit beat (fixed at 8; other values unsupported)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept a command
cmd_base  in  ADDR_W  buffer start byte address; must be 8-byte aligned
cmd_len  in  LEN_W  buffer length in bytes
cmd_scalar  in  1  1 = scalar-broadcast operand mode for every beat
abort  in  1  terminate the current command
beat_valid  out  1  beat presented
beat_ready  in  1  datapath accepts beat
beat_addr  out  ADDR_W  beat word address
beat_lane_mask  out  LANES  active byte lanes; bit i = byte i
beat_se_sel  out  1  select for the operand-2 scalar extender
beat_last  out  1  final beat of the command
busy  out  1  command in progress (state != IDLE)
done  out  1  one-cycle completion pulse
err  out  1  one-cycle misaligned-command pulse

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - All outputs 0, including cmd_ready.
  - cmd_ready rises on the first clk edge after reset deasserts.
  - Reset mid-command drops all outputs to 0 immediately; the command is discarded and done is not pulsed.
- States: IDLE, ISSUE, FINISH. All outputs are registered.
- IDLE:
  - cmd_ready = 1.
  - Accept occurs on cmd_valid && cmd_ready at edge N.
  - If cmd_base[2:0] != 0: err = 1 during cycle N+1, stay in IDLE, cmd_ready stays 1, no beats issued.
  - Else if cmd_len == 0: go to FINISH, no beats issued.
  - Else latch base, remaining = cmd_len and se_sel = cmd_scalar, then go to ISSUE.
  - cmd_ready = 0 in ISSUE and FINISH.
- ISSUE:
  - First beat_valid = 1 in cycle N+1.
  - beat_lane_mask = 8'hFF if remaining >= 8, else (1 << remaining) - 1.
  - beat_last = (remaining <= 8).
  - beat_se_sel is constant for the whole command.
  - While beat_valid && !beat_ready, all beat_* outputs hold stable.
  - On a handshake: addr += 8 (modulo 2^ADDR_W, wrap is silent), remaining -= 8.
  - The next beat is presented the following cycle, so back-to-back beats occur at full rate when beat_ready is held high.
  - A handshake with beat_last = 1 goes to FINISH and beat_valid falls next cycle.
  - Beat count per command = ceil(cmd_len / 8).
- abort:
  - Sampled only in ISSUE; ignored in IDLE and FINISH.
  - On abort, go to FINISH and drop beat_valid next cycle.
  - If abort coincides with a handshake, that beat counts as transferred; no further beats are issued.
- FINISH: done = 1 for exactly one cycle, then IDLE with cmd_ready = 1 next cycle.
- busy = 1 in ISSUE and FINISH.
- cmd_* inputs are ignored outside an IDLE accept.

Decomposition:
- Package vec_seq_pkg:
  - state enum {IDLE, ISSUE, FINISH}.
  - BYTES_PER_BEAT = 8 and BEAT_SHIFT = 3.
  - Lane-mask width typedef.
- One sub-module, lane_mask_gen: combinational remaining → {mask, last}; tested standalone.

Test Plan:
- Basic run: base=0x100, len=24, scalar=0, beat_ready tied 1 → 3 beats, addr 0x100/0x108/0x110, mask FF each, last only on beat 3, se_sel=0; done 1 cycle after beat 3; cmd_ready high the cycle after done.
- Partial beat, scalar mode: base=0x200, len=13, scalar=1 → beats at 0x200 mask FF and 0x208 mask 1F (last); se_sel=1 on both.
- Backpressure: len=16, beat_ready low for 3 cycles on beat 1 → addr/mask/last stable throughout; exactly 2 handshakes total.
- Degenerate and error commands:
  - len=0 → no beat_valid; done pulses once; busy high for 1 cycle.
  - base=0x103 → err pulse 1 cycle; no beats; no done.
- Abort: len=32, abort coincident with the beat-2 handshake → exactly 2 beats transferred, then done.
- Reset mid-command: reset asserted mid-beat-3 of len=32 → outputs 0 asynchronously; no done; cmd_ready returns 1 the first edge after release.
- Address wrap: base=0xFFFF_FFF8, len=16 → beat addresses 0xFFFF_FFF8 then 0x0000_0000; no err.
